// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the truth-table sequencer and the function block / board I/O.
interface truth_table_sequencer_if;
  logic       run_en;
  logic       step_btn;
  logic [6:0] f_seg;
  logic [2:0] abc;
  logic [6:0] hex_idx;
  logic [6:0] hex_res;
  logic [7:0] result_vec;
  logic       mismatch;
  logic       sweep_done;
  logic       busy;

  modport master (
    input  run_en, step_btn, f_seg,
    output abc, hex_idx, hex_res, result_vec, mismatch, sweep_done, busy
  );

  modport slave (
    output run_en, step_btn, f_seg,
    input  abc, hex_idx, hex_res, result_vec, mismatch, sweep_done, busy
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Steps a 3-input function through all eight input combinations, samples its
// 7-segment result and checks it against an expected truth table.
module truth_table_sequencer #(
  parameter int unsigned DWELL_CYCLES    = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [7:0]  EXPECT          = 8'b0011_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sequencer_if.master bus
);

  localparam int unsigned DBW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW         = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned DWELL_LOAD = (DWELL_CYCLES > 3) ? DWELL_CYCLES - 3 : 0;

  localparam logic [6:0] SEG_ONE  = 7'b1111001;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DWELL} state_t;

  function automatic logic [6:0] seg_digit(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  logic           btn_meta, btn_sync;
  logic           db_level, db_prev;
  logic [DBW-1:0] db_cnt;
  logic           step_pulse;

  state_t         state, state_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [DW-1:0]  dwell_cnt, dwell_nxt;
  logic           sweep_nxt;
  logic           f_one, f_valid, sample_bad;

  // Button: 2-FF synchroniser, then a level that only follows a sustained change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= bus.step_btn;
      btn_sync <= btn_meta;
      db_prev  <= db_level;
      if (btn_sync != db_level) begin
        if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= btn_sync;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_pulse = db_level & ~db_prev;

  always_comb begin
    f_one      = (bus.f_seg == SEG_ONE);
    f_valid    = f_one || (bus.f_seg == SEG_ZERO);
    sample_bad = !f_valid || (f_one != EXPECT[idx]);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell_cnt;
    sweep_nxt = 1'b0;
    case (state)
      IDLE:   if (bus.run_en || step_pulse) state_nxt = APPLY;
      APPLY:  state_nxt = SAMPLE;
      SAMPLE: begin
        if (bus.run_en) begin
          state_nxt = DWELL;
          dwell_nxt = DW'(DWELL_LOAD);
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = IDLE;
        end
      end
      DWELL: begin
        // APPLY + SAMPLE + DWELL together span DWELL_CYCLES per index
        if (dwell_cnt == '0) begin
          idx_nxt   = idx + 3'd1;
          sweep_nxt = (idx == 3'd7);
          state_nxt = bus.run_en ? APPLY : IDLE;
        end else begin
          dwell_nxt = dwell_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // abc and hex_idx load from idx_nxt so they track idx with no extra lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      dwell_cnt      <= '0;
      bus.abc        <= '0;
      bus.hex_idx    <= SEG_ZERO;
      bus.hex_res    <= SEG_ZERO;
      bus.result_vec <= '0;
      bus.mismatch   <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      dwell_cnt      <= dwell_nxt;
      bus.abc        <= idx_nxt;
      bus.hex_idx    <= seg_digit(idx_nxt);
      bus.sweep_done <= sweep_nxt;
      if (state == SAMPLE) begin
        bus.hex_res         <= bus.f_seg;
        bus.result_vec[idx] <= f_one;
        bus.mismatch        <= ((idx == 3'd0) ? 1'b0 : bus.mismatch) | sample_bad;
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule
